mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port memory arbiter for instruction fetch and load/store
module mem_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iFetchReq,
    input  logic [AW-1:0] iFetchAddr,
    input  logic          iDataRead,
    input  logic          iDataWrite,
    input  logic [AW-1:0] iDataAddr,
    input  logic [DW-1:0] iDataWdata,
    input  logic [2:0]    iDataOpType,
    input  logic [4:0]    iDataRdAddr,
    output logic          oMemReq,
    output logic          oMemWe,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemWdata,
    output logic [3:0]    oMemBe,
    input  logic [DW-1:0] iMemRdata,
    input  logic          iMemAck,
    output logic          oFetchValid,
    output logic [DW-1:0] oFetchData,
    output logic          oDataValid,
    output logic [DW-1:0] oDataRdata,
    output logic [4:0]    oDataRdAddr,
    output logic          oDataErr,
    output logic          oDataBusy
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH_WAIT, S_DATA_WAIT} state_e;

    state_e        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [DW-1:0] fetch_data_q, fetch_data_d;
    logic          data_valid_q, data_valid_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;
    logic [4:0]    data_rd_addr_q, data_rd_addr_d;
    logic          data_err_q, data_err_d;
    logic [1:0]    cap_lsb_q, cap_lsb_d;
    logic [2:0]    cap_op_q, cap_op_d;
    logic [4:0]    cap_rd_q, cap_rd_d;
    logic          cap_store_q, cap_store_d;

    // A requester is still holding its request during its own response cycle,
    // so it is masked there to avoid servicing the same request twice.
    logic data_req, fetch_req, grant_data, grant_fetch, is_store, data_bad, fetch_bad, ack_ok;
    logic [DW-1:0] st_wdata;
    logic [3:0]    st_be;

    assign data_req    = (iDataRead | iDataWrite) & ~(data_valid_q | data_err_q);
    assign fetch_req   = iFetchReq & ~fetch_valid_q;
    assign grant_data  = data_req & (~fetch_req | ~last_data_q);
    assign grant_fetch = fetch_req & ~grant_data;
    assign is_store    = iDataWrite;
    assign fetch_bad   = (iFetchAddr[1:0] != 2'b00);
    assign ack_ok      = iMemAck & ~mem_req_q;
    assign oDataBusy   = iRst & (iDataRead | iDataWrite) & ~(data_valid_q | data_err_q);

    // Illegal funct3 values or a half/word access that crosses its natural alignment.
    assign data_bad = (iDataOpType == 3'b011) || (iDataOpType == 3'b110) || (iDataOpType == 3'b111)
                   || (is_store && iDataOpType[2])
                   || ((iDataOpType[1:0] == 2'b01) && iDataAddr[0])
                   || ((iDataOpType[1:0] == 2'b10) && (iDataAddr[1:0] != 2'b00));

    // Store byte lanes and lane-replicated write data.
    always_comb begin
        st_wdata = iDataWdata;
        st_be    = 4'b1111;
        case (iDataOpType[1:0])
            2'b00: begin
                st_wdata = {4{iDataWdata[7:0]}};
                st_be    = 4'b0001 << iDataAddr[1:0];
            end
            2'b01: begin
                st_wdata = {2{iDataWdata[15:0]}};
                st_be    = 4'b0011 << iDataAddr[1:0];
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] lsb,
                                             input logic [2:0] op);
        logic [31:0] sh;
        sh = word >> {lsb, 3'b000};
        case (op)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b010:  fmt_load = word;
            3'b100:  fmt_load = {24'd0, sh[7:0]};
            3'b101:  fmt_load = {16'd0, sh[15:0]};
            default: fmt_load = 32'd0;
        endcase
    endfunction

    // Next-state: arbitration and command issue in IDLE, response capture in the wait states.
    always_comb begin
        state_d        = state_q;
        last_data_d    = last_data_q;
        mem_req_d      = 1'b0;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        fetch_valid_d  = 1'b0;
        fetch_data_d   = '0;
        data_valid_d   = 1'b0;
        data_rdata_d   = '0;
        data_rd_addr_d = '0;
        data_err_d     = 1'b0;
        cap_lsb_d      = cap_lsb_q;
        cap_op_d       = cap_op_q;
        cap_rd_d       = cap_rd_q;
        cap_store_d    = cap_store_q;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    last_data_d = 1'b1;
                    if (data_bad) begin
                        data_err_d = 1'b1;
                    end else begin
                        state_d     = S_DATA_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {iDataAddr[AW-1:2], 2'b00};
                        mem_wdata_d = is_store ? st_wdata : '0;
                        mem_be_d    = is_store ? st_be : 4'b1111;
                        cap_lsb_d   = iDataAddr[1:0];
                        cap_op_d    = iDataOpType;
                        cap_rd_d    = iDataRdAddr;
                        cap_store_d = is_store;
                    end
                end else if (grant_fetch) begin
                    last_data_d = 1'b0;
                    if (fetch_bad) begin
                        fetch_valid_d = 1'b1;
                    end else begin
                        state_d     = S_FETCH_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {iFetchAddr[AW-1:2], 2'b00};
                        mem_wdata_d = '0;
                        mem_be_d    = 4'b1111;
                    end
                end
            end
            S_FETCH_WAIT: begin
                if (ack_ok) begin
                    state_d       = S_IDLE;
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = iMemRdata;
                end
            end
            S_DATA_WAIT: begin
                if (ack_ok) begin
                    state_d      = S_IDLE;
                    data_valid_d = 1'b1;
                    if (!cap_store_q) begin
                        data_rdata_d   = fmt_load(iMemRdata, cap_lsb_q, cap_op_q);
                        data_rd_addr_d = cap_rd_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q        <= S_IDLE;
            last_data_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= 4'b0000;
            fetch_valid_q  <= 1'b0;
            fetch_data_q   <= '0;
            data_valid_q   <= 1'b0;
            data_rdata_q   <= '0;
            data_rd_addr_q <= '0;
            data_err_q     <= 1'b0;
            cap_lsb_q      <= 2'b00;
            cap_op_q       <= 3'b000;
            cap_rd_q       <= 5'd0;
            cap_store_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_data_q    <= last_data_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_data_q   <= fetch_data_d;
            data_valid_q   <= data_valid_d;
            data_rdata_q   <= data_rdata_d;
            data_rd_addr_q <= data_rd_addr_d;
            data_err_q     <= data_err_d;
            cap_lsb_q      <= cap_lsb_d;
            cap_op_q       <= cap_op_d;
            cap_rd_q       <= cap_rd_d;
            cap_store_q    <= cap_store_d;
        end
    end

    assign oMemReq     = mem_req_q;
    assign oMemWe      = mem_we_q;
    assign oMemAddr    = mem_addr_q;
    assign oMemWdata   = mem_wdata_q;
    assign oMemBe      = mem_be_q;
    assign oFetchValid = fetch_valid_q;
    assign oFetchData  = fetch_data_q;
    assign oDataValid  = data_valid_q;
    assign oDataRdata  = data_rdata_q;
    assign oDataRdAddr = data_rd_addr_q;
    assign oDataErr    = data_err_q;

endmodule
